mm_rr_bridge: RTL and testbench

- Parametrised Avalon-MM bridge that lets N_MASTERS pipelined masters share one pipelined slave (e.g. vjtag master plus CPU data port sharing the sdram controller).
- Arbitrates commands round-robin and tracks outstanding reads in an in-order ID FIFO, so each readdatavalid reaches the master that issued the read.
- Exposes an 8-bit wrapping count of accepted transactions for board LEDs, and a sticky orphan-response error flag.

---
 rtl/mm_bridge_pkg.sv | 20 ++
 rtl/mm_id_fifo.sv | 47 ++++
 rtl/mm_rr_bridge.sv | 139 +++++++++++++
 tb/tb_mm_rr_bridge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mm_bridge_pkg.sv
// rtl/mm_bridge_pkg.sv - shared constants and helpers for the round-robin MM bridge
package mm_bridge_pkg;
  localparam int CNT_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // ID width for n masters; a single master still needs one bit of ID
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/mm_id_fifo.sv
// rtl/mm_id_fifo.sv - in-order FIFO of master IDs for outstanding reads
module mm_id_fifo
  import mm_bridge_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_id,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_id,
  output logic [clog2(DEPTH):0]   count,
  output logic                    empty,
  output logic                    full
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/mm_rr_bridge.sv
// rtl/mm_rr_bridge.sv - round-robin bridge letting several pipelined MM masters share one slave
module mm_rr_bridge
  import mm_bridge_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_address,
  input  logic [N_MASTERS-1:0]            m_read,
  input  logic [N_MASTERS-1:0]            m_write,
  input  logic [N_MASTERS*DATA_W-1:0]     m_writedata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_byteenable,
  output logic [N_MASTERS-1:0]            m_waitrequest,
  output logic [DATA_W-1:0]               m_readdata,
  output logic [N_MASTERS-1:0]            m_readdatavalid,
  output logic [ADDR_W-1:0]               s_address,
  output logic                            s_read,
  output logic                            s_write,
  output logic [DATA_W-1:0]               s_writedata,
  output logic [DATA_W/8-1:0]             s_byteenable,
  input  logic                            s_waitrequest,
  input  logic [DATA_W-1:0]               s_readdata,
  input  logic                            s_readdatavalid,
  output logic [CNT_W-1:0]                access_count,
  output logic                            rsp_orphan
);
  localparam int BE_W = DATA_W / 8;
  localparam int ID_W = id_width(N_MASTERS);
  localparam int PC_W = clog2(MAX_PENDING) + 1;

  logic [ID_W-1:0]      prio;
  logic [ID_W-1:0]      sel;
  logic [ID_W-1:0]      next_prio;
  logic [ID_W-1:0]      head_id;
  logic [PC_W-1:0]      pend_cnt;
  logic [N_MASTERS-1:0] elig;
  logic                 read_room;
  logic                 found;
  logic                 active;
  logic                 rd_sel;
  logic                 wr_sel;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;

  assign read_room = (pend_cnt < PC_W'(MAX_PENDING));

  // A master raising both read and write is treated as a reader
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_MASTERS; i++)
      elig[i] = m_read[i] ? read_room : m_write[i];
  end

  // Scan downward so the last hit is the first eligible master at or after prio
  always_comb begin
    int idx;
    idx   = 0;
    sel   = prio;
    found = 1'b0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = (int'(prio) + k) % N_MASTERS;
      if (elig[idx]) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    s_address    = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    rd_sel       = 1'b0;
    wr_sel       = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (sel == ID_W'(i)) begin
        s_address    = m_address[slice_lo(i, ADDR_W) +: ADDR_W];
        s_writedata  = m_writedata[slice_lo(i, DATA_W) +: DATA_W];
        s_byteenable = m_byteenable[slice_lo(i, BE_W) +: BE_W];
        rd_sel       = m_read[i];
        wr_sel       = m_write[i];
      end
    end
  end

  assign active     = found & ~rst;
  assign s_read     = active & rd_sel;
  assign s_write    = active & ~rd_sel & wr_sel;
  assign accept     = (s_read | s_write) & ~s_waitrequest;
  assign push       = accept & s_read & ~fifo_full;
  assign pop        = s_readdatavalid & ~fifo_empty & ~rst;
  assign next_prio  = ID_W'((int'(sel) + 1) % N_MASTERS);
  assign m_readdata = s_readdata;

  always_comb begin
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (active && sel == ID_W'(i)) m_waitrequest[i] = s_waitrequest;
      if (pop && head_id == ID_W'(i)) m_readdatavalid[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= '0;
      access_count <= '0;
      rsp_orphan   <= 1'b0;
    end else begin
      if (accept) begin
        prio         <= next_prio;
        access_count <= access_count + CNT_W'(1);
      end
      if (s_readdatavalid && fifo_empty) rsp_orphan <= 1'b1;
    end
  end

  mm_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_PENDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .head_id (head_id),
    .count   (pend_cnt),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );
endmodule

// File: tb/tb_mm_rr_bridge.sv
// tb/tb_mm_rr_bridge.sv - directed self-checking bench for mm_rr_bridge with two masters
module tb_mm_rr_bridge;
  logic        clk;
  logic        rst;
  logic [63:0] m_address;
  logic [1:0]  m_read;
  logic [1:0]  m_write;
  logic [63:0] m_writedata;
  logic [7:0]  m_byteenable;
  logic [1:0]  m_waitrequest;
  logic [31:0] m_readdata;
  logic [1:0]  m_readdatavalid;
  logic [31:0] s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [7:0]  access_count;
  logic        rsp_orphan;

  int errors = 0;
  int checks = 0;

  mm_rr_bridge #(
    .N_MASTERS   (2),
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_PENDING (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .access_count    (access_count),
    .rsp_orphan      (rsp_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    m_address       = {32'h20, 32'h10};
    m_read          = 2'b00;
    m_write         = 2'b11;
    m_writedata     = {32'hCAFEF00D, 32'hDEADBEEF};
    m_byteenable    = {4'h3, 4'hF};
    s_waitrequest   = 1'b0;
    s_readdata      = 32'h0;
    s_readdatavalid = 1'b1;
    tick();
    tick();
    chk("rst_s_write", {31'b0, s_write}, 32'd0);
    chk("rst_m_wait", {30'b0, m_waitrequest}, 32'h3);
    chk("rst_m_rdv", {30'b0, m_readdatavalid}, 32'h0);

    rst = 1'b0; m_write = 2'b00; s_readdatavalid = 1'b0;
    tick();
    chk("rst_count", {24'b0, access_count}, 32'd0);
    chk("rst_orphan", {31'b0, rsp_orphan}, 32'd0);
    chk("rst_pend", 32'(dut.pend_cnt), 32'd0);

    // single write from master 0
    m_write = 2'b01;
    #1;
    chk("w0_s_write", {31'b0, s_write}, 32'd1);
    chk("w0_s_addr", s_address, 32'h10);
    chk("w0_s_data", s_writedata, 32'hDEADBEEF);
    chk("w0_s_be", {28'b0, s_byteenable}, 32'hF);
    chk("w0_m_wait", {30'b0, m_waitrequest}, 32'h2);
    tick();
    m_write = 2'b00;
    chk("w0_count", {24'b0, access_count}, 32'd1);

    // both masters write continuously; prio is now 1
    m_write = 2'b11;
    #1;
    chk("alt0_addr", s_address, 32'h20);
    chk("alt0_be", {28'b0, s_byteenable}, 32'h3);
    tick();
    chk("alt1_addr", s_address, 32'h10);
    tick();
    chk("alt2_addr", s_address, 32'h20);
    tick();
    chk("alt3_addr", s_address, 32'h10);
    tick();
    m_write = 2'b00;
    chk("alt_count", {24'b0, access_count}, 32'd5);

    // master 1 fills the read FIFO
    m_address[63:32] = 32'h100;
    m_read = 2'b10;
    for (int i = 0; i < 4; i++) tick();
    chk("full_pend", 32'(dut.pend_cnt), 32'd4);
    m_write = 2'b01;
    #1;
    chk("full_m_wait", {30'b0, m_waitrequest}, 32'h2);
    chk("full_s_read", {31'b0, s_read}, 32'd0);
    chk("full_s_write", {31'b0, s_write}, 32'd1);
    tick();
    m_write = 2'b00;
    chk("full_count", {24'b0, access_count}, 32'd10);
    s_readdatavalid = 1'b1; s_readdata = 32'h1234;
    #1;
    chk("full_rdv", {30'b0, m_readdatavalid}, 32'h2);
    chk("full_rdata", m_readdata, 32'h1234);
    chk("full_pop_wait", {30'b0, m_waitrequest}, 32'h3);
    chk("full_pop_s_read", {31'b0, s_read}, 32'd0);
    tick();
    s_readdatavalid = 1'b0;
    #1;
    chk("fifth_s_read", {31'b0, s_read}, 32'd1);
    chk("fifth_m_wait", {30'b0, m_waitrequest}, 32'h1);
    chk("fifth_addr", s_address, 32'h100);
    tick();
    m_read = 2'b00;
    chk("fifth_pend", 32'(dut.pend_cnt), 32'd4);
    s_readdatavalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_rdv", {30'b0, m_readdatavalid}, 32'h2);
      tick();
    end
    s_readdatavalid = 1'b0;
    chk("drain_pend", 32'(dut.pend_cnt), 32'd0);

    // interleaved reads m0, m1, m0
    m_read = 2'b01; tick();
    m_read = 2'b10; tick();
    m_read = 2'b01; tick();
    m_read = 2'b00;
    chk("il_count", {24'b0, access_count}, 32'd14);
    s_readdatavalid = 1'b1; s_readdata = 32'hA;
    #1;
    chk("il_rdv_a", {30'b0, m_readdatavalid}, 32'h1);
    chk("il_data_a", m_readdata, 32'hA);
    tick();
    s_readdata = 32'hB;
    #1;
    chk("il_rdv_b", {30'b0, m_readdatavalid}, 32'h2);
    chk("il_data_b", m_readdata, 32'hB);
    tick();
    s_readdata = 32'hC;
    #1;
    chk("il_rdv_c", {30'b0, m_readdatavalid}, 32'h1);
    chk("il_data_c", m_readdata, 32'hC);
    tick();

    // orphan response with empty FIFO
    #1;
    chk("orph_rdv", {30'b0, m_readdatavalid}, 32'h0);
    chk("orph_pre", {31'b0, rsp_orphan}, 32'd0);
    tick();
    s_readdatavalid = 1'b0;
    chk("orph_set", {31'b0, rsp_orphan}, 32'd1);
    tick();
    tick();
    chk("orph_sticky", {31'b0, rsp_orphan}, 32'd1);

    // stalled slave holds the command and the counter
    s_waitrequest = 1'b1; m_write = 2'b01;
    #1;
    chk("stall_s_write", {31'b0, s_write}, 32'd1);
    chk("stall_m_wait", {30'b0, m_waitrequest}, 32'h3);
    tick();
    chk("stall_count", {24'b0, access_count}, 32'd14);
    s_waitrequest = 1'b0;
    for (int i = 0; i < 241; i++) tick();
    chk("wrap_255", {24'b0, access_count}, 32'd255);
    tick();
    m_write = 2'b00;
    chk("wrap_0", {24'b0, access_count}, 32'd0);

    // reset with reads outstanding drops their IDs
    m_read = 2'b01; tick(); tick();
    m_read = 2'b00;
    chk("rr_pend2", 32'(dut.pend_cnt), 32'd2);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rr_pend0", 32'(dut.pend_cnt), 32'd0);
    chk("rr_count", {24'b0, access_count}, 32'd0);
    chk("rr_orphan_clr", {31'b0, rsp_orphan}, 32'd0);
    s_readdatavalid = 1'b1;
    #1;
    chk("rr_rdv", {30'b0, m_readdatavalid}, 32'h0);
    tick();
    s_readdatavalid = 1'b0;
    chk("rr_orphan_set", {31'b0, rsp_orphan}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
